// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising receive checker for the 24-bit noise LFSR tap stream.
// Define LFSR_CHECKER_STATS_EN to implement the locked-sample counter on sample_count_o.
module lfsr_checker #(
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   input  logic [15:0]      in_word_i,
   input  logic             clear_stats_i,
   output logic             locked_o,
   output logic             err_pulse_o,
   output logic [ERR_W-1:0] err_count_o,
   output logic [31:0]      sample_count_o
);
   typedef enum logic {HUNT, LOCKED} state_e;
   state_e           state_q, state_d;
   logic [23:0]      shadow_q, shadow_d;
   logic [4:0]       fill_q, fill_d;
   logic [3:0]       miss_q, miss_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] ecnt_q, ecnt_d;
   logic [23:0]      pred, shifted;
   logic [4:0]       fill_inc;
   logic [3:0]       miss_inc;
   assign pred     = {shadow_q[22:0], shadow_q[23] ^ shadow_q[22] ^ shadow_q[20] ^ shadow_q[19]};
   assign shifted  = {shadow_q[22:0], in_word_i[0]};
   assign fill_inc = (fill_q == 5'd24) ? fill_q : fill_q + 5'd1;
   assign miss_inc = miss_q + 4'd1;
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      fill_d   = fill_q;
      miss_d   = miss_q;
      err_d    = 1'b0;
      ecnt_d   = ecnt_q;
      if (in_valid_i) begin
         if (state_q == HUNT) begin
            shadow_d = shifted;
            fill_d   = fill_inc;
            if (fill_inc == 5'd24) begin
               // all-zero state is never generated, so restart the fill
               if (shifted == '0) fill_d = '0;
               else if (shifted[15:0] == in_word_i) begin
                  state_d = LOCKED;
                  miss_d  = '0;
               end
            end
         end else if (pred[15:0] == in_word_i) begin
            shadow_d = pred;
            miss_d   = '0;
         end else begin
            err_d    = 1'b1;
            ecnt_d   = (&ecnt_q) ? ecnt_q : ecnt_q + 1'b1;
            miss_d   = miss_inc;
            shadow_d = shifted;
            if (miss_inc == 4'(LOSS_THRESH)) begin
               state_d = HUNT;
               fill_d  = '0;
               miss_d  = '0;
            end
         end
      end
      if (clear_stats_i) ecnt_d = '0;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= HUNT;
         shadow_q <= '0;
         fill_q   <= '0;
         miss_q   <= '0;
         err_q    <= 1'b0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         fill_q   <= fill_d;
         miss_q   <= miss_d;
         err_q    <= err_d;
         ecnt_q   <= ecnt_d;
      end
   end
   assign locked_o    = (state_q == LOCKED);
   assign err_pulse_o = err_q;
   assign err_count_o = ecnt_q;
`ifdef LFSR_CHECKER_STATS_EN
   logic [31:0] scnt_q, scnt_d;
   assign scnt_d = clear_stats_i ? 32'd0 : (in_valid_i && state_q == LOCKED) ? scnt_q + 32'd1 : scnt_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) scnt_q <= '0;
      else scnt_q <= scnt_d;
   end
   assign sample_count_o = scnt_q;
`else
   assign sample_count_o = '0;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scenarios against a reference generator, checked by a scoreboard.
module tb_lfsr_checker;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clear_stats = 1'b0;
   logic [15:0] in_word = '0;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic [31:0] sample_count;

   always #5 clk = ~clk;

   lfsr_checker #(.LOSS_THRESH(4), .ERR_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_word_i(in_word),
      .clear_stats_i(clear_stats), .locked_o(locked), .err_pulse_o(err_pulse),
      .err_count_o(err_count), .sample_count_o(sample_count)
   );

   typedef struct {
      int          tag;
      logic        lk;
      logic        ep;
      logic [15:0] ec;
      logic [31:0] sc;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          checks = 0, passed = 0;
   logic [23:0] g;
   logic [31:0] sc = 0;
   logic        cur_lk = 1'b0;

   function automatic logic [23:0] nxt(input logic [23:0] s);
      return {s[22:0], s[23] ^ s[22] ^ s[20] ^ s[19]};
   endfunction

   task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s[s%0d] got %0h want %0h at %0t", nm, tag, got, want, $time);
   endtask

   // each sample's expectation is pushed on a negedge and checked just after the consuming posedge
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("locked", e.tag, 32'(locked), 32'(e.lk));
         chk("err_pulse", e.tag, 32'(err_pulse), 32'(e.ep));
         chk("err_count", e.tag, 32'(err_count), 32'(e.ec));
         chk("sample_count", e.tag, sample_count, e.sc);
      end
   end

   task automatic step(input logic v, input logic [15:0] w, input logic clr, input int tag,
                       input logic lk, input logic ep, input logic [15:0] ec);
      exp_t x;
      @(negedge clk);
      in_valid = v; in_word = w; clear_stats = clr;
      if (clr) sc = 0;
      else if (v && cur_lk) sc = sc + 1;
      x.tag = tag; x.lk = lk; x.ep = ep; x.ec = ec;
`ifdef LFSR_CHECKER_STATS_EN
      x.sc = sc;
`else
      x.sc = 0;
`endif
      q.push_back(x);
      cur_lk = lk;
   endtask

   task automatic gstep(input int tag, input logic lk, input logic ep, input logic [15:0] ec,
                        input logic [15:0] flip, input logic clr);
      g = nxt(g);
      step(1'b1, g[15:0] ^ flip, clr, tag, lk, ep, ec);
   endtask

   task automatic do_reset(input int tag);
      @(negedge clk);
      in_valid = 1'b0; clear_stats = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_locked", tag, 32'(locked), 0);
      chk("rst_err_pulse", tag, 32'(err_pulse), 0);
      chk("rst_err_count", tag, 32'(err_count), 0);
      chk("rst_sample_count", tag, sample_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cur_lk = 1'b0; sc = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_locked", 0, 32'(locked), 0);
      chk("rst_err_count", 0, 32'(err_count), 0);
      chk("rst_sample_count", 0, sample_count, 0);
      rst_n = 1'b1;
      // clean stream from seed 1: lock after the 24th sample, never an error
      g = 24'h000001;
      for (int n = 1; n <= 10000; n++) gstep(1, n >= 24, 1'b0, 16'd0, 16'h0000, 1'b0);
      // single bit-5 flip, then a clean sample still matches
      gstep(2, 1'b1, 1'b1, 16'd1, 16'h0020, 1'b0);
      gstep(2, 1'b1, 1'b0, 16'd1, 16'h0000, 1'b0);
      // four consecutive misses drop lock; relock after 24 valid samples
      for (int k = 1; k <= 4; k++) gstep(3, k < 4, 1'b1, 16'(1 + k), 16'h0020, 1'b0);
      for (int n = 1; n <= 30; n++) gstep(3, n >= 24, 1'b0, 16'd5, 16'h0000, 1'b0);
      gstep(3, 1'b1, 1'b1, 16'd6, 16'h0020, 1'b0);
      gstep(3, 1'b1, 1'b0, 16'd6, 16'h0000, 1'b0);
      gstep(3, 1'b1, 1'b1, 16'd7, 16'h0020, 1'b0);
      gstep(3, 1'b1, 1'b0, 16'd7, 16'h0000, 1'b0);
      // reset while locked with err_count = 7
      do_reset(6);
      // sparse valid (1 of 3), garbage on idle cycles
      g = 24'h000001;
      for (int n = 1; n <= 40; n++) begin
         gstep(4, n >= 24, 1'b0, 16'd0, 16'h0000, 1'b0);
         step(1'b0, 16'($urandom), 1'b0, 4, n >= 24, 1'b0, 16'd0);
         step(1'b0, 16'($urandom), 1'b0, 4, n >= 24, 1'b0, 16'd0);
      end
      for (int k = 1; k <= 3; k++) begin
         gstep(7, 1'b1, 1'b1, 16'(k), 16'h0020, 1'b0);
         gstep(7, 1'b1, 1'b0, 16'(k), 16'h0000, 1'b0);
      end
      // clear coincident with an error: clear wins
      gstep(7, 1'b1, 1'b1, 16'd0, 16'h0020, 1'b1);
      gstep(7, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b0);
      gstep(7, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b0);
      // all-zero words never lock
      do_reset(8);
      for (int n = 1; n <= 30; n++) step(1'b1, 16'h0000, 1'b0, 5, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      if (q.size() != 0) chk("queue_drained", 9, 32'(q.size()), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 24-bit noise LFSR: consumes the 16-bit low tap word (state bits 15:0) one step per valid sample and self-synchronises a shadow copy of the generator state. Once locked, it predicts every following word and flags mismatches, counts errors and drops lock after a run of consecutive misses. Sits on the noise bus as a built-in self-test monitor for the voice noise path and for bring-up on hardware.

## Interface
- LOSS_THRESH, 4: consecutive mismatching samples that force loss of lock (1..15)
- ERR_W, 16: width of the saturating error counter
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  one generator step is presented this cycle
- in_word  in  16  generator tap word, state[15:0] after the step (signed on the bus, treated as raw bits here)
- locked  out  1  shadow state synchronised and tracking
- err_pulse  out  1  one-cycle flag: sample mismatched prediction while locked
- err_count  out  ERR_W  saturating count of mismatches since reset/clear
- sample_count  out  32  valid samples seen while locked (stats build only)
- clear_stats  in  1  synchronous clear of err_count and sample_count

## Operation
- Polynomial matches generator: fb = s[23]^s[22]^s[20]^s[19]; next = {s[22:0], fb}.
- Shadow register shadow[23:0]; fill counter fill[4:0]; miss counter miss[3:0].
- States: HUNT, LOCKED.
- HUNT: on each in_valid, shadow <= {shadow[22:0], in_word[0]}, fill += 1 (saturating at 24). When fill reaches 24 on a valid sample, and the resulting shadow is non-zero, and its [15:0] equals in_word, go LOCKED, miss <= 0. Zero shadow at fill = 24: stay HUNT, fill <= 0 (generator never emits all-zero state; treat as garbage).
- LOCKED: pred = next(shadow). If pred[15:0] == in_word: shadow <= pred, miss <= 0. Else: err_pulse, err_count += 1 (saturate at all-ones), miss += 1, shadow <= {shadow[22:0], in_word[0]} (resync path). If miss reaches LOSS_THRESH: go HUNT, fill <= 0, miss <= 0.
- in_valid low: no state change in any state; err_pulse low.
- clear_stats same cycle as error: clear wins, counter reads 0 next cycle.
- Reset mid-operation: immediately HUNT, all counters 0, shadow 0.

## Timing
- All outputs registered; reset value 0 for locked, err_pulse, err_count, sample_count.
- Lock: locked high the cycle after the 24th consecutive-valid accepted sample (minimum 24 valid cycles from reset).
- err_pulse high exactly one cycle, the cycle after the mismatching sample's in_valid.
- locked falls the cycle after the LOSS_THRESH-th consecutive miss; that sample also pulses err_pulse.
- Gaps in in_valid are transparent; prediction advances only on valid samples.
- Throughput: one sample per clock, no backpressure.

## Configuration
- LFSR_CHECKER_STATS_EN defined: sample_count implemented, increments on every valid sample while locked (wraps at 2^32), cleared by clear_stats.
- Not defined: sample_count tied to 0, counter logic removed; err_count, err_pulse and locking unchanged.

## Test plan
- Reset, generator seeded 24'h000001 stepping every cycle -> locked rises on cycle 25 after reset release, err_pulse never asserts over 10000 samples, err_count = 0.
- Locked stream, flip in_word bit 5 on one sample -> single err_pulse one cycle later, err_count = 1, locked stays high, next clean sample matches.
- Locked, inject 4 consecutive corrupted words (LOSS_THRESH = 4) -> 4 err_pulses, locked low after 4th, relock 24 valid samples later.
- in_valid toggled 1-of-3 cycles from seed 24'h000001 -> lock after 24 valid samples, zero errors.
- in_word held 16'h0000 for 30 samples after reset -> locked stays 0, err_count = 0.
- Assert reset for one cycle while locked with err_count = 7 -> all outputs 0 immediately; with STATS_EN, sample_count 0 and clear_stats clears count = 3 to 0.
